// File: rtl/nvdla_csb_seq_pkg.sv
// Shared types and widths for the NVDLA CSB command sequencer.
`timescale 1ns/1ps
package nvdla_csb_seq_pkg;
    localparam int CSB_AW = 16;
    localparam int CSB_DW = 32;

    typedef enum logic [1:0] {
        OP_WR    = 2'd0,
        OP_WR_NP = 2'd1,
        OP_RD    = 2'd2,
        OP_POLL  = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_WRC,
        ST_WAIT_RD,
        ST_GAP,
        ST_RESP
    } state_e;

    function automatic logic poll_match(input logic [CSB_DW-1:0] data,
                                        input logic [CSB_DW-1:0] exp_v,
                                        input logic [CSB_DW-1:0] mask);
        return ((data ^ exp_v) & mask) == '0;
    endfunction
endpackage

// File: rtl/nvdla_csb_sequencer.sv
// Single-outstanding CSB command sequencer: writes, reads and masked register polls.
// Define NVDLA_CSB_SEQ_TIMEOUT_EN to bound POLL duration by POLL_TIMEOUT cycles.
`timescale 1ns/1ps
module nvdla_csb_sequencer
    import nvdla_csb_seq_pkg::*;
#(
    parameter int unsigned POLL_GAP     = 4,
    parameter int unsigned POLL_TIMEOUT = 65535
) (
    input  logic              csb_clk,
    input  logic              csb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CSB_AW-1:0] cmd_addr,
    input  logic [CSB_DW-1:0] cmd_wdat,
    input  logic [CSB_DW-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CSB_DW-1:0] rsp_data,
    output logic              rsp_err,
    output logic              csb2nvdla_valid,
    input  logic              csb2nvdla_ready,
    output logic [CSB_AW-1:0] csb2nvdla_addr,
    output logic [CSB_DW-1:0] csb2nvdla_wdat,
    output logic              csb2nvdla_write,
    output logic              csb2nvdla_nposted,
    input  logic              nvdla2csb_valid,
    input  logic [CSB_DW-1:0] nvdla2csb_data,
    input  logic              nvdla2csb_wr_complete,
    output logic              busy
);
    localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

    state_e            state_q;
    cmd_op_e           op_q;
    logic [CSB_AW-1:0] addr_q;
    logic [CSB_DW-1:0] wdat_q, mask_q, rdata_q, csb_wdat_q;
    logic [15:0]       gap_q;
    logic              cmd_ready_q, csb_valid_q, csb_wr_q, csb_np_q, rsp_valid_q, busy_q;
    logic              accept;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
    logic        err_q;
    logic [31:0] tmo_q;

    // Cleared on every accept; only consulted while a POLL sits in GAP.
    always_ff @(posedge csb_clk) begin
        if (csb_rst)
            tmo_q <= '0;
        else if (state_q == ST_IDLE && accept)
            tmo_q <= '0;
        else if (state_q == ST_ISSUE || state_q == ST_WAIT_RD || state_q == ST_GAP)
            tmo_q <= tmo_q + 32'd1;
    end
    assign rsp_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^32'(POLL_TIMEOUT);
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge csb_clk) begin
        if (csb_rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WR;
            addr_q      <= '0;
            wdat_q      <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            csb_wdat_q  <= '0;
            gap_q       <= '0;
            cmd_ready_q <= 1'b1;
            csb_valid_q <= 1'b0;
            csb_wr_q    <= 1'b0;
            csb_np_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q        <= cmd_op_e'(cmd_op);
                    addr_q      <= cmd_addr;
                    wdat_q      <= cmd_wdat;
                    mask_q      <= cmd_mask;
                    rdata_q     <= '0;
                    csb_wr_q    <= (cmd_op_e'(cmd_op) == OP_WR) || (cmd_op_e'(cmd_op) == OP_WR_NP);
                    csb_np_q    <= (cmd_op_e'(cmd_op) == OP_WR_NP);
                    csb_wdat_q  <= (cmd_op_e'(cmd_op) == OP_WR || cmd_op_e'(cmd_op) == OP_WR_NP)
                                   ? cmd_wdat : '0;
                    cmd_ready_q <= 1'b0;
                    csb_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                    state_q     <= ST_ISSUE;
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
                    err_q       <= 1'b0;
`endif
                end
                // A return arriving in the same cycle as ready is dropped by design.
                ST_ISSUE: if (csb2nvdla_ready) begin
                    csb_valid_q <= 1'b0;
                    case (op_q)
                        OP_WR: begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                        OP_WR_NP: state_q <= ST_WAIT_WRC;
                        default:  state_q <= ST_WAIT_RD;
                    endcase
                end
                ST_WAIT_WRC: if (nvdla2csb_wr_complete) begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_WAIT_RD: if (nvdla2csb_valid) begin
                    rdata_q <= nvdla2csb_data;
                    if (op_q == OP_RD || poll_match(nvdla2csb_data, wdat_q, mask_q)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
                    if (tmo_q >= 32'(POLL_TIMEOUT)) begin
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else
`endif
                    if (gap_q == GAP_LAST) begin
                        csb_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    csb_valid_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready         = cmd_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rdata_q;
    assign csb2nvdla_valid   = csb_valid_q;
    assign csb2nvdla_addr    = addr_q;
    assign csb2nvdla_wdat    = csb_wdat_q;
    assign csb2nvdla_write   = csb_wr_q;
    assign csb2nvdla_nposted = csb_np_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_nvdla_csb_sequencer.sv
// Self-checking bench for nvdla_csb_sequencer: bench acts as host and CSB slave.
`timescale 1ns/1ps
module tb_nvdla_csb_sequencer;
    localparam int GAP = 4;
    localparam int TMO = 40;
    localparam int LIMIT = 400;

    logic        csb_clk = 0, csb_rst = 1;
    logic        cmd_valid = 0, cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [15:0] cmd_addr = 0;
    logic [31:0] cmd_wdat = 0, cmd_mask = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_err;
    logic [31:0] rsp_data;
    logic        csb2nvdla_valid, csb2nvdla_ready = 0, csb2nvdla_write, csb2nvdla_nposted;
    logic [15:0] csb2nvdla_addr;
    logic [31:0] csb2nvdla_wdat;
    logic        nvdla2csb_valid = 0, nvdla2csb_wr_complete = 0;
    logic [31:0] nvdla2csb_data = 0;
    logic        busy;

    int total = 0, bad = 0;
    logic [31:0] rd_q[$];

    typedef struct {
        int          nreq;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        wr, np, err;
        logic [31:0] rdata;
        int          lat, min_gap;
        bit          unstable, rsp_drop, idle_ok, timeout;
    } obs_t;

    nvdla_csb_sequencer #(.POLL_GAP(GAP), .POLL_TIMEOUT(TMO)) dut (
        .csb_clk(csb_clk), .csb_rst(csb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .csb2nvdla_valid(csb2nvdla_valid), .csb2nvdla_ready(csb2nvdla_ready),
        .csb2nvdla_addr(csb2nvdla_addr), .csb2nvdla_wdat(csb2nvdla_wdat),
        .csb2nvdla_write(csb2nvdla_write), .csb2nvdla_nposted(csb2nvdla_nposted),
        .nvdla2csb_valid(nvdla2csb_valid), .nvdla2csb_data(nvdla2csb_data),
        .nvdla2csb_wr_complete(nvdla2csb_wr_complete), .busy(busy)
    );

    always #5 csb_clk = ~csb_clk;

    task automatic tick();
        @(posedge csb_clk);
        #1;
    endtask

    // Plays host and slave for one command; only observes, never judges.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wdat,
                           input logic [31:0] mask, input int rdy_dly, input int ret_dly,
                           input int rsp_dly, output obs_t o);
        int stall, ret_at, rsp_cnt, last_ret, w;
        bit in_req, got_rsp, done;
        o = '{default: 0};
        o.min_gap = 1000;
        stall = 0; ret_at = -1; rsp_cnt = 0; last_ret = -1;
        in_req = 0; got_rsp = 0; done = 0;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin tick(); w++; end
        if (cmd_ready !== 1'b1) begin o.timeout = 1; return; end
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_wdat = wdat; cmd_mask = mask;
        tick();
        cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = 16'($urandom);
        cmd_wdat = $urandom; cmd_mask = $urandom;
        for (w = 1; w <= LIMIT && !done; w++) begin
            nvdla2csb_valid = 0; nvdla2csb_wr_complete = 0; nvdla2csb_data = $urandom;
            if (w == ret_at) begin
                if (op == 2'd1) nvdla2csb_wr_complete = 1;
                else begin
                    nvdla2csb_valid = 1;
                    nvdla2csb_data  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
                end
                last_ret = w; ret_at = -1;
            end
            csb2nvdla_ready = 0;
            if (csb2nvdla_valid === 1'b1) begin
                if (o.nreq == 0) begin
                    o.addr = csb2nvdla_addr; o.wdat = csb2nvdla_wdat;
                    o.wr = csb2nvdla_write;  o.np = csb2nvdla_nposted;
                end else if (csb2nvdla_addr !== o.addr || csb2nvdla_wdat !== o.wdat ||
                             csb2nvdla_write !== o.wr || csb2nvdla_nposted !== o.np)
                    o.unstable = 1;
                if (!in_req) begin
                    in_req = 1; stall = rdy_dly; o.nreq++;
                    if (last_ret >= 0 && (w - last_ret - 1) < o.min_gap) o.min_gap = w - last_ret - 1;
                end
                if (stall == 0) begin
                    csb2nvdla_ready = 1; in_req = 0;
                    if (op != 2'd0) ret_at = w + 1 + ret_dly;
                end else stall--;
            end
            if (!got_rsp) begin
                if (rsp_valid === 1'b1) begin
                    got_rsp = 1; o.lat = w; o.rdata = rsp_data; o.err = rsp_err; rsp_cnt = rsp_dly;
                end
            end else if (rsp_ready === 1'b1) begin
                o.idle_ok = (rsp_valid === 1'b0 && busy === 1'b0 && cmd_ready === 1'b1);
                done = 1;
            end else if (rsp_valid !== 1'b1 || rsp_data !== o.rdata || rsp_err !== o.err)
                o.rsp_drop = 1;
            rsp_ready = 0;
            if (got_rsp && !done) begin
                if (rsp_cnt == 0) rsp_ready = 1; else rsp_cnt--;
            end
            if (!done) tick();
        end
        if (!done) o.timeout = 1;
        rsp_ready = 0; csb2nvdla_ready = 0; nvdla2csb_valid = 0; nvdla2csb_wr_complete = 0;
    endtask

    task automatic test_reset();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if (csb2nvdla_valid !== 1'b0) begin bad++; $display("FAIL rst_csb_valid got=%b exp=0", csb2nvdla_valid); end
        total++; if ({rsp_data, rsp_err} !== 33'h0) begin bad++; $display("FAIL rst_rsp got=%h/%b exp=0", rsp_data, rsp_err); end
        total++; if ({csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted} !== 50'h0) begin
            bad++; $display("FAIL rst_csb_fields got=%h/%h/%b/%b exp=0", csb2nvdla_addr, csb2nvdla_wdat,
                            csb2nvdla_write, csb2nvdla_nposted);
        end
    endtask

    task automatic test_write();
        obs_t o;
        run_cmd(2'd0, 16'h1004, 32'hA5A5_0001, 32'h0, 0, 0, 0, o);
        total++; if (o.timeout) begin bad++; $display("FAIL wr_timeout got=1 exp=0"); end
        total++; if (o.nreq !== 1) begin bad++; $display("FAIL wr_nreq got=%0d exp=1", o.nreq); end
        total++; if ({o.addr, o.wdat, o.wr, o.np} !== {16'h1004, 32'hA5A5_0001, 1'b1, 1'b0}) begin
            bad++; $display("FAIL wr_req got=%h/%h/%b/%b exp=1004/a5a50001/1/0", o.addr, o.wdat, o.wr, o.np);
        end
        total++; if (o.lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", o.lat); end
        total++; if (o.rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp_data got=%h exp=0", o.rdata); end
        total++; if (!o.idle_ok) begin bad++; $display("FAIL wr_idle_after got=0 exp=1"); end
    endtask

    task automatic test_write_np();
        obs_t o;
        run_cmd(2'd1, 16'h2000, 32'h1234_5678, 32'h0, 0, 4, 0, o);
        total++; if ({o.wr, o.np} !== 2'b11) begin bad++; $display("FAIL wrnp_flags got=%b%b exp=11", o.wr, o.np); end
        // wr_complete 5 cycles after the handshake; response the cycle after it is seen
        total++; if (o.lat !== 7) begin bad++; $display("FAIL wrnp_latency got=%0d exp=7", o.lat); end
        total++; if (o.rdata !== 32'h0 || o.timeout) begin bad++; $display("FAIL wrnp_rsp got=%h to=%b exp=0", o.rdata, o.timeout); end
    endtask

    task automatic test_read();
        obs_t o;
        rd_q.delete(); rd_q.push_back(32'hDEAD_BEEF);
        run_cmd(2'd2, 16'h0004, 32'hFFFF_FFFF, 32'h0, 4, 2, 0, o);
        total++; if (o.unstable) begin bad++; $display("FAIL rd_stall_stable got=unstable exp=stable"); end
        total++; if ({o.addr, o.wdat, o.wr, o.np} !== {16'h0004, 32'h0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rd_req got=%h/%h/%b/%b exp=0004/0/0/0", o.addr, o.wdat, o.wr, o.np);
        end
        total++; if (o.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", o.rdata); end
        total++; if (o.lat !== 2 + 4 + 3) begin bad++; $display("FAIL rd_latency got=%0d exp=9", o.lat); end
    endtask

    task automatic test_poll();
        obs_t o;
        rd_q.delete(); rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h1);
        run_cmd(2'd3, 16'h000C, 32'h1, 32'h1, 0, 1, 0, o);
        total++; if (o.nreq !== 3) begin bad++; $display("FAIL poll_nreq got=%0d exp=3", o.nreq); end
        total++; if (o.min_gap < GAP) begin bad++; $display("FAIL poll_gap got=%0d exp>=%0d", o.min_gap, GAP); end
        total++; if (o.rdata !== 32'h1 || o.err !== 1'b0) begin bad++; $display("FAIL poll_rsp got=%h/%b exp=1/0", o.rdata, o.err); end
        total++; if (o.unstable || o.addr !== 16'h000C) begin bad++; $display("FAIL poll_addr got=%h exp=000c", o.addr); end
        rd_q.delete(); rd_q.push_back(32'hCAFE_0000);
        run_cmd(2'd3, 16'h0010, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, o);
        total++; if (o.nreq !== 1 || o.rdata !== 32'hCAFE_0000) begin
            bad++; $display("FAIL poll_mask0 got=%0d/%h exp=1/cafe0000", o.nreq, o.rdata);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            run_cmd(2'd0, 16'(16'h0100 + i), 32'($urandom), 32'h0, 0, 0, 3, o);
            total++; if (o.rsp_drop || !o.idle_ok || o.timeout) begin
                bad++; $display("FAIL b2b_rsp_hold[%0d] got=drop%b/idle%b/to%b exp=0/1/0", i, o.rsp_drop, o.idle_ok, o.timeout);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] wdat, mask, last;
        logic [31:0] seq[$];
        int rdy, ret, k, exp_n, exp_lat;
        logic [31:0] exp_d;
        for (int it = 0; it < 40; it++) begin
            op = 2'($urandom_range(0, 3)); addr = 16'($urandom); wdat = $urandom;
            mask = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            rdy = $urandom_range(0, 3); ret = $urandom_range(0, 3);
            seq.delete();
            k = (op == 2'd3) ? $urandom_range(1, 3) : 1;
            for (int j = 0; j < k - 1; j++) seq.push_back($urandom);
            last = (wdat & mask) | ($urandom & ~mask);
            seq.push_back((op == 2'd3) ? last : $urandom);
            // reference: first read satisfying the masked compare ends the poll
            exp_n = 1; exp_d = 32'h0;
            if (op >= 2'd2) begin
                exp_d = seq[0];
                if (op == 2'd3)
                    for (int j = 0; j < seq.size(); j++)
                        if (((seq[j] ^ wdat) & mask) == 0) begin exp_n = j + 1; exp_d = seq[j]; break; end
            end
            exp_lat = (op == 2'd0) ? 2 + rdy : 2 + rdy + ret + 1;
            rd_q = seq;
            run_cmd(op, addr, wdat, mask, rdy, ret, $urandom_range(0, 2), o);
            total++; if (o.timeout || o.nreq !== exp_n) begin
                bad++; $display("FAIL rnd_nreq[%0d] op=%0d got=%0d to=%b exp=%0d", it, op, o.nreq, o.timeout, exp_n);
            end
            total++; if (o.rdata !== exp_d) begin bad++; $display("FAIL rnd_data[%0d] op=%0d got=%h exp=%h", it, op, o.rdata, exp_d); end
            total++; if ({o.addr, o.wr, o.np, o.wdat} !== {addr, op <= 2'd1, op == 2'd1, (op <= 2'd1) ? wdat : 32'h0}) begin
                bad++; $display("FAIL rnd_req[%0d] op=%0d got=%h/%b/%b/%h exp=%h", it, op, o.addr, o.wr, o.np, o.wdat, addr);
            end
            total++; if (o.unstable || o.rsp_drop || !o.idle_ok || o.err !== 1'b0) begin
                bad++; $display("FAIL rnd_proto[%0d] got=unst%b/drop%b/idle%b/err%b exp=0/0/1/0", it, o.unstable, o.rsp_drop, o.idle_ok, o.err);
            end
            if (op != 2'd3) begin
                total++; if (o.lat !== exp_lat) begin bad++; $display("FAIL rnd_lat[%0d] op=%0d got=%0d exp=%0d", it, op, o.lat, exp_lat); end
            end else if (exp_n > 1) begin
                total++; if (o.min_gap < GAP) begin bad++; $display("FAIL rnd_gap[%0d] got=%0d exp>=%0d", it, o.min_gap, GAP); end
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int w;
        cmd_valid = 1; cmd_op = 2'd2; cmd_addr = 16'h0040;
        tick();
        cmd_valid = 0;
        w = 0;
        while (csb2nvdla_valid !== 1'b1 && w < 20) begin tick(); w++; end
        total++; if (csb2nvdla_valid !== 1'b1) begin bad++; $display("FAIL rmid_issue got=0 exp=1"); end
        csb2nvdla_ready = 1; tick(); csb2nvdla_ready = 0; tick();
        csb_rst = 1; tick(); csb_rst = 0;
        total++; if ({busy, cmd_ready, rsp_valid, csb2nvdla_valid} !== 4'b0100) begin
            bad++; $display("FAIL rmid_after_rst got=%b%b%b%b exp=0100", busy, cmd_ready, rsp_valid, csb2nvdla_valid);
        end
        nvdla2csb_valid = 1; nvdla2csb_data = 32'h5555_AAAA; nvdla2csb_wr_complete = 1;
        tick();
        nvdla2csb_valid = 0; nvdla2csb_wr_complete = 0;
        tick();
        total++; if ({busy, rsp_valid, rsp_data} !== 34'h0) begin
            bad++; $display("FAIL rmid_stray got=busy%b/rv%b/%h exp=0/0/0", busy, rsp_valid, rsp_data);
        end
        rd_q.delete(); rd_q.push_back(32'h0BAD_F00D);
        run_cmd(2'd2, 16'h0044, 32'h0, 32'h0, 1, 1, 0, o);
        total++; if (o.rdata !== 32'h0BAD_F00D || o.nreq !== 1) begin
            bad++; $display("FAIL rmid_recover got=%h/%0d exp=0badf00d/1", o.rdata, o.nreq);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        bit extra;
        rd_q.delete();
        run_cmd(2'd3, 16'h000C, 32'h1, 32'h1, 0, 1, 0, o);
`ifdef NVDLA_CSB_SEQ_TIMEOUT_EN
        total++; if (o.err !== 1'b1 || o.rdata !== 32'h0 || o.timeout) begin
            bad++; $display("FAIL tmo_err got=err%b/%h/to%b exp=1/0/0", o.err, o.rdata, o.timeout);
        end
        total++; if (o.lat < TMO || o.lat > TMO + GAP + 10 || o.nreq < 2) begin
            bad++; $display("FAIL tmo_latency got=%0d/%0d exp=%0d..%0d", o.lat, o.nreq, TMO, TMO + GAP + 10);
        end
`else
        // without the bounding counter a never-matching poll must still be running
        total++; if (!o.timeout || busy !== 1'b1) begin
            bad++; $display("FAIL notmo_poll got=to%b/busy%b exp=1/1", o.timeout, busy);
        end
        csb_rst = 1; tick(); csb_rst = 0;
`endif
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (csb2nvdla_valid === 1'b1 || rsp_err === 1'b1 && rsp_valid === 1'b0 && busy === 1'b1) extra = 1;
            tick();
        end
        total++; if (extra) begin bad++; $display("FAIL tmo_quiet got=activity exp=none"); end
    endtask

    initial begin
        repeat (3) tick();
        csb_rst = 0;
        test_reset();
        test_write();
        test_write_np();
        test_read();
        test_poll();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
